// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin share of one combinational ALU between two requesters, each with a one-entry valid/ready response slot
module alu_arbiter #(
  parameter int WIDTH = 32,
  parameter int CTRL_W = 5,
  parameter int MAX_OP = 21
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              r0_valid,
  output logic              r0_ready,
  input  logic [WIDTH-1:0]  r0_a,
  input  logic [WIDTH-1:0]  r0_b,
  input  logic [CTRL_W-1:0] r0_op,
  input  logic              r1_valid,
  output logic              r1_ready,
  input  logic [WIDTH-1:0]  r1_a,
  input  logic [WIDTH-1:0]  r1_b,
  input  logic [CTRL_W-1:0] r1_op,
  output logic              r0_rsp_valid,
  input  logic              r0_rsp_ready,
  output logic [WIDTH-1:0]  r0_rsp_data,
  output logic              r0_rsp_err,
  output logic              r1_rsp_valid,
  input  logic              r1_rsp_ready,
  output logic [WIDTH-1:0]  r1_rsp_data,
  output logic              r1_rsp_err,
  output logic [WIDTH-1:0]  alu_a,
  output logic [WIDTH-1:0]  alu_b,
  output logic [CTRL_W-1:0] alu_ctrl,
  input  logic [WIDTH-1:0]  alu_result
);
  logic elig0, elig1, gnt0, gnt1, last_gnt, legal;
  logic [WIDTH-1:0] res;
  always_comb begin
    elig0 = r0_valid & (~r0_rsp_valid | r0_rsp_ready);
    elig1 = r1_valid & (~r1_rsp_valid | r1_rsp_ready);
    gnt0 = elig0 & (~elig1 | last_gnt);
    gnt1 = elig1 & ~gnt0;
    r0_ready = gnt0;
    r1_ready = gnt1;
    alu_a = gnt0 ? r0_a : gnt1 ? r1_a : '0;
    alu_b = gnt0 ? r0_b : gnt1 ? r1_b : '0;
    alu_ctrl = gnt0 ? r0_op : gnt1 ? r1_op : '0;
    legal = alu_ctrl <= CTRL_W'(MAX_OP);
    res = legal ? alu_result : '0;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_gnt <= 1'b1;
      r0_rsp_valid <= 1'b0;
      r0_rsp_data <= '0;
      r0_rsp_err <= 1'b0;
      r1_rsp_valid <= 1'b0;
      r1_rsp_data <= '0;
      r1_rsp_err <= 1'b0;
    end else begin
      if (gnt0 | gnt1) last_gnt <= gnt1;
      if (gnt0) begin
        r0_rsp_valid <= 1'b1;
        r0_rsp_data <= res;
        r0_rsp_err <= ~legal;
      end else if (r0_rsp_ready) r0_rsp_valid <= 1'b0;
      if (gnt1) begin
        r1_rsp_valid <= 1'b1;
        r1_rsp_data <= res;
        r1_rsp_err <= ~legal;
      end else if (r1_rsp_ready) r1_rsp_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed self-checking bench for alu_arbiter with a small behavioural ALU
module tb_alu_arbiter;
  logic clk = 0, rst;
  logic r0_valid, r0_ready, r1_valid, r1_ready;
  logic [31:0] r0_a, r0_b, r1_a, r1_b;
  logic [4:0] r0_op, r1_op, alu_ctrl;
  logic r0_rsp_valid, r0_rsp_ready, r0_rsp_err, r1_rsp_valid, r1_rsp_ready, r1_rsp_err;
  logic [31:0] r0_rsp_data, r1_rsp_data, alu_a, alu_b, alu_result;
  int total = 0, bad = 0;
  alu_arbiter dut (
    .clk(clk), .rst(rst),
    .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_a(r0_a), .r0_b(r0_b), .r0_op(r0_op),
    .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_a(r1_a), .r1_b(r1_b), .r1_op(r1_op),
    .r0_rsp_valid(r0_rsp_valid), .r0_rsp_ready(r0_rsp_ready), .r0_rsp_data(r0_rsp_data), .r0_rsp_err(r0_rsp_err),
    .r1_rsp_valid(r1_rsp_valid), .r1_rsp_ready(r1_rsp_ready), .r1_rsp_data(r1_rsp_data), .r1_rsp_err(r1_rsp_err),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl), .alu_result(alu_result)
  );
  always #5 clk = ~clk;
  always_comb
    alu_result = alu_ctrl == 5'b00000 ? alu_a + alu_b :
                 alu_ctrl == 5'b00010 ? alu_a - alu_b :
                 alu_ctrl == 5'b10100 ? ((alu_a + alu_b) == 32'h108 ? 32'h42 : 32'h0) :
                 32'hDEADBEEF;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    rst = 1;
    {r0_valid, r1_valid, r0_rsp_ready, r1_rsp_ready} = '0;
    {r0_a, r0_b, r1_a, r1_b} = '0;
    r0_op = 0;
    r1_op = 0;
    #12;
    chk("rst_r0_vld", 32'(r0_rsp_valid), 0);
    chk("rst_r1_vld", 32'(r1_rsp_valid), 0);
    chk("rst_r0_data", r0_rsp_data, 0);
    chk("rst_alu_ctrl", 32'(alu_ctrl), 0);
    rst = 0;
    tick();
    r0_valid = 1; r0_op = 5'b00000; r0_a = 5; r0_b = 7; r0_rsp_ready = 1;
    #1;
    chk("t1_r0_ready", 32'(r0_ready), 1);
    chk("t1_r1_ready", 32'(r1_ready), 0);
    chk("t1_alu_a", alu_a, 5);
    tick();
    r0_valid = 0;
    chk("t1_rsp_vld", 32'(r0_rsp_valid), 1);
    chk("t1_rsp_data", r0_rsp_data, 12);
    chk("t1_rsp_err", 32'(r0_rsp_err), 0);
    #1;
    chk("idle_alu_a", alu_a, 0);
    chk("idle_alu_ctrl", 32'(alu_ctrl), 0);
    rst = 1; #1; rst = 0;
    r0_valid = 1; r0_a = 1; r0_b = 10; r1_valid = 1; r1_op = 0; r1_a = 2; r1_b = 20;
    r0_rsp_ready = 1; r1_rsp_ready = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("t2_r0_ready%0d", i), 32'(r0_ready), 32'(i % 2 == 0));
      chk($sformatf("t2_r1_ready%0d", i), 32'(r1_ready), 32'(i % 2 == 1));
      tick();
      chk($sformatf("t2_r0_vld%0d", i), 32'(r0_rsp_valid), 32'(i % 2 == 0));
      chk($sformatf("t2_r1_vld%0d", i), 32'(r1_rsp_valid), 32'(i % 2 == 1));
      if (i % 2 == 0) chk($sformatf("t2_r0_data%0d", i), r0_rsp_data, 11);
      else chk($sformatf("t2_r1_data%0d", i), r1_rsp_data, 22);
    end
    r1_valid = 0; r0_a = 100; r0_b = 1; r0_rsp_ready = 0;
    #1;
    chk("t3_fill_ready", 32'(r0_ready), 1);
    tick();
    r0_a = 200; r0_b = 2; r1_valid = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("t3_r0_blk%0d", i), 32'(r0_ready), 0);
      chk($sformatf("t3_r1_gnt%0d", i), 32'(r1_ready), 1);
      tick();
      chk($sformatf("t3_hold%0d", i), r0_rsp_data, 101);
    end
    r0_rsp_ready = 1;
    #1;
    chk("t3_drain_r0", 32'(r0_ready), 1);
    chk("t3_drain_r1", 32'(r1_ready), 0);
    tick();
    chk("t3_b2b_vld", 32'(r0_rsp_valid), 1);
    chk("t3_b2b_data", r0_rsp_data, 202);
    r0_valid = 0;
    r1_op = 5'b00010; r1_a = 3; r1_b = 5;
    tick();
    chk("t4_sub", r1_rsp_data, 32'hFFFFFFFE);
    chk("t4_sub_err", 32'(r1_rsp_err), 0);
    r1_op = 5'b10100; r1_a = 32'h100; r1_b = 32'h8;
    tick();
    chk("t4_lw", r1_rsp_data, 32'h42);
    r1_valid = 0;
    r0_valid = 1; r0_op = 5'b11111; r0_a = 9; r0_b = 9;
    tick();
    chk("t5_ill_data", r0_rsp_data, 0);
    chk("t5_ill_err", 32'(r0_rsp_err), 1);
    r0_op = 5'b00000; r0_a = 1; r0_b = 1;
    tick();
    chk("t5_clr_err", 32'(r0_rsp_err), 0);
    chk("t5_clr_data", r0_rsp_data, 2);
    r0_valid = 0; r0_rsp_ready = 0;
    r1_valid = 1; r1_op = 0; r1_a = 4; r1_b = 4; r1_rsp_ready = 0;
    tick();
    r1_valid = 0;
    chk("t6_pre_vld", 32'(r1_rsp_valid), 1);
    #2;
    rst = 1;
    #1;
    chk("t6_r0_vld", 32'(r0_rsp_valid), 0);
    chk("t6_r1_vld", 32'(r1_rsp_valid), 0);
    chk("t6_r1_data", r1_rsp_data, 0);
    @(negedge clk);
    rst = 0;
    r0_valid = 1; r1_valid = 1; r0_op = 0; r1_op = 0;
    #1;
    chk("t6_first_r0", 32'(r0_ready), 1);
    chk("t6_first_r1", 32'(r1_ready), 0);
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
